sevenseg_scan_driver: RTL and testbench

Parametrised multi-digit 7-segment display driver. It is the time-multiplexed successor to the single-digit BCD decoder.
- Latches an N-digit BCD/hex value, scans one digit per refresh slot and drives shared segment lines plus per-digit anode enables.
- Adds leading-zero blanking, per-digit decimal points, hex glyphs and polarity selection.
- Sits between counter/timer logic and board display pins.

---
 rtl/sevenseg_scan_driver_pkg.sv | 32 +++
 rtl/seg7_glyph_decode.sv | 38 +++
 rtl/sevenseg_scan_driver.sv | 122 ++++++++++++
 tb/tb_sevenseg_scan_driver.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_scan_driver_pkg.sv
// Shared constants for the multiplexed 7-segment driver.
// The glyphs are active-low abcdefg: bit 6 is segment a and bit 0 is segment g.
package sevenseg_scan_driver_pkg;

  localparam logic [6:0] ZERO  = 7'b0000001;
  localparam logic [6:0] ONE   = 7'b1001111;
  localparam logic [6:0] TWO   = 7'b0010010;
  localparam logic [6:0] THREE = 7'b0000110;
  localparam logic [6:0] FOUR  = 7'b1001100;
  localparam logic [6:0] FIVE  = 7'b0100100;
  localparam logic [6:0] SIX   = 7'b0100000;
  localparam logic [6:0] SEVEN = 7'b0001111;
  localparam logic [6:0] EIGHT = 7'b0000000;
  localparam logic [6:0] NINE  = 7'b0000100;
  localparam logic [6:0] HEX_A = 7'b0001000;
  localparam logic [6:0] HEX_B = 7'b1100000;
  localparam logic [6:0] HEX_C = 7'b0110001;
  localparam logic [6:0] HEX_D = 7'b1000010;
  localparam logic [6:0] HEX_E = 7'b0110000;
  localparam logic [6:0] HEX_F = 7'b0111000;
  localparam logic [6:0] BLANK = 7'b1111111;

  // Number of bits needed to count 0..n-1. Returns at least 1, so a
  // single-digit build still has a legal index register.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Converts a 4-bit digit code to an active-low abcdefg glyph.
// When hex_en_i is low, codes 10..15 produce a blank glyph.
// When blank_i is high, every code produces a blank glyph.
module seg7_glyph_decode
  import sevenseg_scan_driver_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       hex_en_i,
  input  logic       blank_i,
  output logic [6:0] glyph_o
);

  // Glyph lookup
  always_comb begin
    glyph_o = BLANK;
    if (!blank_i) begin
      case (code_i)
        4'd0:    glyph_o = ZERO;
        4'd1:    glyph_o = ONE;
        4'd2:    glyph_o = TWO;
        4'd3:    glyph_o = THREE;
        4'd4:    glyph_o = FOUR;
        4'd5:    glyph_o = FIVE;
        4'd6:    glyph_o = SIX;
        4'd7:    glyph_o = SEVEN;
        4'd8:    glyph_o = EIGHT;
        4'd9:    glyph_o = NINE;
        4'd10:   glyph_o = hex_en_i ? HEX_A : BLANK;
        4'd11:   glyph_o = hex_en_i ? HEX_B : BLANK;
        4'd12:   glyph_o = hex_en_i ? HEX_C : BLANK;
        4'd13:   glyph_o = hex_en_i ? HEX_D : BLANK;
        4'd14:   glyph_o = hex_en_i ? HEX_E : BLANK;
        default: glyph_o = hex_en_i ? HEX_F : BLANK;
      endcase
    end
  end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver.
// The display is driven only from shadow registers, which are captured on load.
// Each digit stays lit for REFRESH_DIV clock cycles.
// seg, dp and an are all registered, so they change together on the same edge.
module sevenseg_scan_driver
  import sevenseg_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 100000,
  parameter int HEX_EN         = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    digit_tick
);

  localparam int unsigned IDX_W = clog2(NUM_DIGITS);
  localparam int unsigned DIV_W = clog2(REFRESH_DIV);

  localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [4*NUM_DIGITS-1:0] val_sh_q;
  logic [NUM_DIGITS-1:0]   dps_q;
  logic                    lz_q;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    last_slot;
  logic [3:0]              cur_code;
  logic                    cur_dp, lz_hide, dp_lit;
  logic [NUM_DIGITS-1:0]   sel;
  logic [6:0]              glyph;
  logic [6:0]              seg_q, seg_d;
  logic                    dpo_q, dpo_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  // Refresh divider and digit index advance
  always_comb begin
    last_slot = (div_q == DIV_W'(REFRESH_DIV - 1));
    div_d     = div_q + DIV_W'(1);
    idx_d     = idx_q;
    if (last_slot) begin
      div_d = '0;
      if (idx_q == IDX_W'(NUM_DIGITS - 1)) idx_d = '0;
      else                                 idx_d = idx_q + IDX_W'(1);
    end
  end

  // Select the current digit and decide whether it is a leading zero to hide
  always_comb begin
    cur_code = '0;
    cur_dp   = 1'b0;
    sel      = '0;
    // A digit is blanked when it and every more-significant digit are zero.
    // Digit 0 is never blanked.
    lz_hide  = lz_q && (idx_q != '0);
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (32'(idx_q) == i) begin
        sel[i]   = 1'b1;
        cur_code = val_sh_q[4*i +: 4];
        cur_dp   = dps_q[i];
      end
      if (32'(idx_q) <= i && val_sh_q[4*i +: 4] != 4'd0) lz_hide = 1'b0;
    end
  end

  seg7_glyph_decode u_decode (
    .code_i   (cur_code),
    .hex_en_i (HEX_EN != 0),
    .blank_i  (lz_hide),
    .glyph_o  (glyph)
  );

  // Apply the board polarity before the output register
  always_comb begin
    dp_lit = cur_dp & ~lz_hide;
    seg_d  = (SEG_ACTIVE_LOW != 0) ? glyph   : ~glyph;
    dpo_d  = (SEG_ACTIVE_LOW != 0) ? ~dp_lit : dp_lit;
    an_d   = (AN_ACTIVE_LOW != 0)  ? ~sel    : sel;
  end

  // Shadow capture, scan state and registered display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      val_sh_q <= '0;
      dps_q    <= '0;
      lz_q     <= 1'b0;
      div_q    <= '0;
      idx_q    <= '0;
      seg_q    <= SEG_OFF;
      dpo_q    <= DP_OFF;
      an_q     <= AN_OFF;
    end else begin
      if (load) begin
        val_sh_q <= value;
        dps_q    <= dp_in;
        lz_q     <= lz_blank;
      end
      div_q <= div_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      dpo_q <= dpo_d;
      an_q  <= an_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dpo_q;
  assign an         = an_q;
  assign digit_tick = last_slot;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver. It runs four instances in lockstep:
//   a: the default board polarity, with hex glyphs enabled
//   b: HEX_EN=0, so hex codes show as blank
//   c: active-high segments and anodes
//   d: a single-digit build
module tb_sevenseg_scan_driver;

  localparam logic [6:0] G_0   = 7'b0000001;
  localparam logic [6:0] G_1   = 7'b1001111;
  localparam logic [6:0] G_2   = 7'b0010010;
  localparam logic [6:0] G_3   = 7'b0000110;
  localparam logic [6:0] G_4   = 7'b1001100;
  localparam logic [6:0] G_7   = 7'b0001111;
  localparam logic [6:0] G_A   = 7'b0001000;
  localparam logic [6:0] G_B   = 7'b1100000;
  localparam logic [6:0] G_C   = 7'b0110001;
  localparam logic [6:0] G_F   = 7'b0111000;
  localparam logic [6:0] G_OFF = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        lz_blank;
  logic        load;

  logic [6:0] seg_a, seg_b, seg_c, seg_d;
  logic       dp_a, dp_b, dp_c, dp_d;
  logic [3:0] an_a, an_b, an_c;
  logic [0:0] an_d;
  logic       tick_a, tick_b, tick_c, tick_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sevenseg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_EN(1),
                         .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_a (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .lz_blank(lz_blank),
    .load(load), .seg(seg_a), .dp(dp_a), .an(an_a), .digit_tick(tick_a));

  sevenseg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_EN(0),
                         .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .lz_blank(lz_blank),
    .load(load), .seg(seg_b), .dp(dp_b), .an(an_b), .digit_tick(tick_b));

  sevenseg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_EN(1),
                         .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) dut_c (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .lz_blank(lz_blank),
    .load(load), .seg(seg_c), .dp(dp_c), .an(an_c), .digit_tick(tick_c));

  sevenseg_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(3), .HEX_EN(1),
                         .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_d (
    .clk(clk), .rst(rst), .value(value[3:0]), .dp_in(dp_in[0:0]), .lz_blank(lz_blank),
    .load(load), .seg(seg_d), .dp(dp_d), .an(an_d), .digit_tick(tick_d));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected values are written for the default-polarity instance.
  // Instance b uses its own expected segment value.
  // Instance c must show the bitwise inverse of every expected value.
  task automatic check_digit(input string tag, input logic [3:0] ean, input logic [6:0] eseg,
                             input logic edp, input logic [6:0] eseg_b);
    logic [3:0] nan;
    logic [6:0] nseg;
    logic       ndp;
    nan  = ~ean;
    nseg = ~eseg;
    ndp  = ~edp;
    check_eq({tag, "_an_a"},  32'(an_a),  32'(ean));
    check_eq({tag, "_seg_a"}, 32'(seg_a), 32'(eseg));
    check_eq({tag, "_dp_a"},  32'(dp_a),  32'(edp));
    check_eq({tag, "_an_b"},  32'(an_b),  32'(ean));
    check_eq({tag, "_seg_b"}, 32'(seg_b), 32'(eseg_b));
    check_eq({tag, "_dp_b"},  32'(dp_b),  32'(edp));
    check_eq({tag, "_an_c"},  32'(an_c),  32'(nan));
    check_eq({tag, "_seg_c"}, 32'(seg_c), 32'(nseg));
    check_eq({tag, "_dp_c"},  32'(dp_c),  32'(ndp));
  endtask

  // Wait a bounded number of cycles for digit_tick.
  // When exp_wait is zero or more, also check how many cycles the wait took.
  task automatic wait_tick(input int exp_wait);
    int w;
    w = 0;
    while (tick_a !== 1'b1 && w < 12) begin
      step();
      w++;
    end
    if (tick_a !== 1'b1) check_eq("tick_timeout", 32'(tick_a), 32'd1);
    else if (exp_wait >= 0) check_eq("tick_period", 32'(w), 32'(exp_wait));
  endtask

  // Return at the first cycle on which the outputs show the next digit.
  task automatic sync_next(input int exp_wait);
    wait_tick(exp_wait);
    step();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int ticks_d;
    logic an_d_ok;

    rst = 1'b1; value = '0; dp_in = '0; lz_blank = 1'b0; load = 1'b0;
    step(); step(); step();

    // Reset values
    check_digit("rst", 4'hF, G_OFF, 1'b1, G_OFF);
    check_eq("rst_tick_a", 32'(tick_a), 0);
    check_eq("rst_tick_b", 32'(tick_b), 0);
    check_eq("rst_tick_c", 32'(tick_c), 0);
    check_eq("rst_an_d",   32'(an_d),   1);

    rst = 1'b0;
    step();
    check_digit("first", 4'hE, G_0, 1'b1, G_0);
    check_eq("first_tick", 32'(tick_a), 0);

    // Scan order using the value 1234
    value = 16'h1234; dp_in = 4'b0000; lz_blank = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    step();
    check_digit("s_d0", 4'hE, G_4, 1'b1, G_4);
    sync_next(0);
    check_eq("tick_low", 32'(tick_a), 0);
    check_digit("s_d1", 4'hD, G_3, 1'b1, G_3);
    sync_next(2); check_digit("s_d2", 4'hB, G_2, 1'b1, G_2);
    sync_next(2); check_digit("s_d3", 4'h7, G_1, 1'b1, G_1);
    sync_next(2); check_digit("s_wrap", 4'hE, G_4, 1'b1, G_4);

    // Leading-zero blanking, which also suppresses the dp of a hidden digit
    value = 16'h0040; dp_in = 4'b1111; lz_blank = 1'b1; load = 1'b1;
    step();
    load = 1'b0;
    sync_next(1); check_digit("lz_d1", 4'hD, G_4,   1'b0, G_4);
    sync_next(2); check_digit("lz_d2", 4'hB, G_OFF, 1'b1, G_OFF);
    sync_next(2); check_digit("lz_d3", 4'h7, G_OFF, 1'b1, G_OFF);
    sync_next(2); check_digit("lz_d0", 4'hE, G_0,   1'b0, G_0);

    value = 16'h0000; dp_in = 4'b0000; load = 1'b1;
    step();
    load = 1'b0;
    sync_next(1); check_digit("z_d1", 4'hD, G_OFF, 1'b1, G_OFF);
    sync_next(2); check_digit("z_d2", 4'hB, G_OFF, 1'b1, G_OFF);
    sync_next(2); check_digit("z_d3", 4'h7, G_OFF, 1'b1, G_OFF);
    sync_next(2); check_digit("z_d0", 4'hE, G_0,   1'b1, G_0);

    // Hex glyphs and the decimal point on digit 2
    value = 16'hABCF; dp_in = 4'b0100; lz_blank = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    sync_next(1); check_digit("h_d1", 4'hD, G_C, 1'b1, G_OFF);
    sync_next(2); check_digit("h_d2", 4'hB, G_B, 1'b0, G_OFF);
    sync_next(2); check_digit("h_d3", 4'h7, G_A, 1'b1, G_OFF);
    sync_next(2); check_digit("h_d0", 4'hE, G_F, 1'b1, G_OFF);

    // Changing value without load leaves the display unchanged
    value = 16'h5555;
    sync_next(2); check_digit("nl_d1", 4'hD, G_C, 1'b1, G_OFF);

    // Load arriving on the same cycle as digit_tick
    wait_tick(2);
    value = 16'h7777; dp_in = 4'b0000; lz_blank = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    check_digit("lt_old", 4'hD, G_C, 1'b1, G_OFF);
    step();
    check_digit("lt_new", 4'hB, G_7, 1'b1, G_7);

    // Reset asserted mid-scan while the display shows digit 2
    rst = 1'b1;
    step();
    check_digit("mr", 4'hF, G_OFF, 1'b1, G_OFF);
    check_eq("mr_tick", 32'(tick_a), 0);
    rst = 1'b0;
    step();
    check_digit("mr_d0", 4'hE, G_0, 1'b1, G_0);
    sync_next(2); check_digit("mr_d1", 4'hD, G_0, 1'b1, G_0);
    sync_next(2); check_digit("mr_d2", 4'hB, G_0, 1'b1, G_0);
    sync_next(2); check_digit("mr_d3", 4'h7, G_0, 1'b1, G_0);

    // Single-digit build: the anode stays enabled and digit_tick still pulses
    ticks_d = 0;
    an_d_ok = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      if (tick_d === 1'b1) ticks_d++;
      if (an_d !== 1'b0) an_d_ok = 1'b0;
    end
    check_eq("d1_ticks", 32'(ticks_d), 32'd3);
    check_eq("d1_an_on", 32'(an_d_ok), 32'd1);
    check_eq("d1_seg",   32'(seg_d),   32'(G_0));
    check_eq("d1_dp",    32'(dp_d),    32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
